adc_serial_rx: RTL and testbench

Parametrised multi-lane serial ADC receiver, the successor to the single-channel 12-bit receiver in the equaliser front end. It captures NCH parallel sdata lanes sharing one CS/SCLK pair and glitch-filters CS and SCLK with configurable depths. It discards LEAD_W leading bits, presents all channel words together in a held output register, and flags frames aborted by an early CS rise. It sits between the ADC pins and the equaliser sample path.

---
 rtl/adc_serial_rx.sv | 154 +++++++++++++++
 tb/tb_adc_serial_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_rx.sv
// Multi-lane serial ADC receiver: glitch-filtered CS/SCLK, LEAD_W discarded bits, NCH parallel words.
// Optional leading-bit check is enabled by defining ADC_RX_LEADCHK_EN.
module adc_serial_rx #(
   parameter int DATA_W    = 12,
   parameter int LEAD_W    = 4,
   parameter int NCH       = 2,
   parameter int CS_FILT   = 8,
   parameter int SCLK_FILT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH-1:0]        sdata,
   input  logic                  sclk,
   input  logic                  cs,
   input  logic                  rx_en,
   output logic [NCH*DATA_W-1:0] dout,
   output logic                  rx_done_tick,
   output logic                  frame_err,
   output logic                  lead_err
);

   localparam int TOTAL = LEAD_W + DATA_W;
   localparam int CNT_W = $clog2(TOTAL + 1);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [CS_FILT-1:0]   cs_sr;
   logic [SCLK_FILT-1:0] sclk_sr;
   logic                 cs_f, cs_f_d;
   logic                 sclk_f, sclk_f_d;
   logic                 cs_fall, cs_rise, sclk_rise;
   logic [NCH-1:0]       sd_q;

   logic [1:0]           state;
   logic [CNT_W-1:0]     cnt;
   logic [DATA_W-1:0]    shreg    [NCH];
   logic [DATA_W-1:0]    shreg_nx [NCH];
   logic [NCH*DATA_W-1:0] word_nx;

   // Filter output only moves once the whole window agrees; mixed windows hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_sr    <= '1;
         cs_f     <= 1'b1;
         cs_f_d   <= 1'b1;
         sclk_sr  <= '0;
         sclk_f   <= 1'b0;
         sclk_f_d <= 1'b0;
         sd_q     <= '0;
      end else begin
         cs_sr   <= {cs_sr[CS_FILT-2:0], cs};
         sclk_sr <= {sclk_sr[SCLK_FILT-2:0], sclk};
         if (cs_sr == '1)
            cs_f <= 1'b1;
         else if (cs_sr == '0)
            cs_f <= 1'b0;
         if (sclk_sr == '1)
            sclk_f <= 1'b1;
         else if (sclk_sr == '0)
            sclk_f <= 1'b0;
         cs_f_d   <= cs_f;
         sclk_f_d <= sclk_f;
         sd_q     <= sdata;
      end
   end

   assign cs_fall   = cs_f_d & ~cs_f;
   assign cs_rise   = ~cs_f_d & cs_f;
   assign sclk_rise = ~sclk_f_d & sclk_f;

   always_comb begin
      word_nx = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         shreg_nx[i] = DATA_W'({shreg[i], sd_q[i]});
         word_nx[i*DATA_W +: DATA_W] = shreg_nx[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
         for (int unsigned i = 0; i < NCH; i++)
            shreg[i] <= '0;
      end else begin
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cs_fall && rx_en) begin
                  cnt   <= CNT_LOAD;
                  state <= ST_SHIFT;
                  for (int unsigned i = 0; i < NCH; i++)
                     shreg[i] <= '0;
               end
            end
            ST_SHIFT: begin
               if (sclk_rise) begin
                  if (cnt <= CNT_DATA)
                     for (int unsigned i = 0; i < NCH; i++)
                        shreg[i] <= shreg_nx[i];
                  // A coincident CS rise only counts as an abort if this was not the last bit.
                  if (cnt == CNT_ONE) begin
                     dout         <= word_nx;
                     rx_done_tick <= 1'b1;
                     state        <= ST_DONE;
                  end else if (cs_rise) begin
                     frame_err <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end else if (cs_rise) begin
                  frame_err <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ADC_RX_LEADCHK_EN
   logic [NCH-1:0] lead_flag;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lead_flag <= '0;
         lead_err  <= 1'b0;
      end else begin
         lead_err <= 1'b0;
         if (state == ST_IDLE && cs_fall && rx_en)
            lead_flag <= '0;
         else if (state == ST_SHIFT && sclk_rise && cnt > CNT_DATA)
            lead_flag <= lead_flag | sd_q;
         if (state == ST_SHIFT && sclk_rise && cnt == CNT_ONE)
            lead_err <= |lead_flag;
      end
   end
`else
   assign lead_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_serial_rx.sv
// Scoreboard bench for adc_serial_rx at default parameters; honours ADC_RX_LEADCHK_EN when defined.
module tb_adc_serial_rx;

   localparam int DATA_W  = 12;
   localparam int NCH     = 2;
   localparam int CS_FILT = 8;
`ifdef ADC_RX_LEADCHK_EN
   localparam bit LEADCHK = 1'b1;
`else
   localparam bit LEADCHK = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst, sclk, cs, rx_en;
   logic [NCH-1:0]        sdata;
   logic [NCH*DATA_W-1:0] dout;
   logic                  rx_done_tick, frame_err, lead_err;

   int n_checks = 0;
   int n_fail   = 0;
   int tick_cnt = 0;
   int ferr_cnt = 0;

   typedef struct {
      logic [23:0] d;
      logic        le;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   adc_serial_rx #(
      .DATA_W(DATA_W), .LEAD_W(4), .NCH(NCH), .CS_FILT(CS_FILT), .SCLK_FILT(2)
   ) dut (
      .clk(clk), .rst(rst), .sdata(sdata), .sclk(sclk), .cs(cs), .rx_en(rx_en),
      .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err), .lead_err(lead_err)
   );

   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1) begin
         if (frame_err) ferr_cnt++;
         if (rx_done_tick) begin
            tick_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL spurious_tick: dout=%h, no frame was expected", dout);
            end else begin
               e = exp_q.pop_front();
               if (dout !== e.d) begin
                  n_fail++;
                  $display("FAIL frame_dout: got %h, expected %h", dout, e.d);
               end
               n_checks++;
               if (lead_err !== e.le) begin
                  n_fail++;
                  $display("FAIL lead_err_at_done: got %b, expected %b", lead_err, e.le);
               end
            end
         end
      end
   end

   task automatic bit_cycle(input logic [NCH-1:0] b);
      sdata = b;
      repeat (6) @(negedge clk);
      sclk = 1'b1;
      repeat (6) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic run_frame(input logic [15:0] w0, input logic [15:0] w1, input int nbits,
                            input int drop_at, input bit expect_done);
      exp_t e;
      if (expect_done) begin
         e.d  = {w1[11:0], w0[11:0]};
         e.le = LEADCHK && ((w0[15:12] | w1[15:12]) != 4'h0);
         exp_q.push_back(e);
      end
      cs = 1'b0;
      repeat (12) @(negedge clk);
      for (int k = 0; k < nbits; k++) begin
         if (k == drop_at) rx_en = 1'b0;
         bit_cycle({w1[15-k], w0[15-k]});
      end
      repeat (4) @(negedge clk);
      cs    = 1'b1;
      sdata = '0;
      repeat (CS_FILT + 8) @(negedge clk);
      rx_en = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; cs = 1'b1; sclk = 1'b0; sdata = '0; rx_en = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (dout !== 24'h0) begin n_fail++; $display("FAIL reset_dout: got %h, expected 000000", dout); end
      n_checks++;
      if (rx_done_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b, expected 0", rx_done_tick); end
      n_checks++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
      n_checks++;
      if (lead_err !== 1'b0) begin n_fail++; $display("FAIL reset_lead_err: got %b, expected 0", lead_err); end
      rst = 1'b1;
      repeat (CS_FILT + 4) @(negedge clk);
   endtask

   task automatic test_basic();
      int t0 = tick_cnt;
      int f0 = ferr_cnt;
      run_frame(16'h0ABC, 16'h0123, 16, -1, 1'b1);
      n_checks++;
      if (tick_cnt !== t0 + 1) begin n_fail++; $display("FAIL basic_ticks: got %0d, expected %0d", tick_cnt, t0 + 1); end
      n_checks++;
      if (ferr_cnt !== f0) begin n_fail++; $display("FAIL basic_frame_err: got %0d, expected %0d", ferr_cnt, f0); end
      n_checks++;
      if (dout !== 24'h123ABC) begin n_fail++; $display("FAIL basic_dout_hold: got %h, expected 123abc", dout); end
   endtask

   task automatic test_cs_glitch();
      int t0 = tick_cnt;
      int f0 = ferr_cnt;
      cs = 1'b0;
      repeat (3) @(negedge clk);
      cs = 1'b1;
      repeat (20) @(negedge clk);
      for (int k = 0; k < 16; k++) bit_cycle(NCH'($urandom_range(3, 0)));
      repeat (10) @(negedge clk);
      n_checks++;
      if (tick_cnt !== t0) begin n_fail++; $display("FAIL glitch_ticks: got %0d, expected %0d", tick_cnt, t0); end
      n_checks++;
      if (ferr_cnt !== f0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d, expected %0d", ferr_cnt, f0); end
      n_checks++;
      if (dout !== 24'h123ABC) begin n_fail++; $display("FAIL glitch_dout: got %h, expected 123abc", dout); end
   endtask

   task automatic test_abort();
      int t0 = tick_cnt;
      int f0 = ferr_cnt;
      run_frame(16'h0F0F, 16'h0777, 10, -1, 1'b0);
      n_checks++;
      if (ferr_cnt !== f0 + 1) begin n_fail++; $display("FAIL abort_frame_err: got %0d, expected %0d", ferr_cnt, f0 + 1); end
      n_checks++;
      if (tick_cnt !== t0) begin n_fail++; $display("FAIL abort_ticks: got %0d, expected %0d", tick_cnt, t0); end
      n_checks++;
      if (dout !== 24'h123ABC) begin n_fail++; $display("FAIL abort_dout: got %h, expected 123abc", dout); end
      run_frame(16'h0FFF, 16'h0001, 16, -1, 1'b1);
      n_checks++;
      if (tick_cnt !== t0 + 1) begin n_fail++; $display("FAIL after_abort_ticks: got %0d, expected %0d", tick_cnt, t0 + 1); end
      n_checks++;
      if (dout !== 24'h001FFF) begin n_fail++; $display("FAIL after_abort_dout: got %h, expected 001fff", dout); end
   endtask

   task automatic test_rx_en();
      int t0 = tick_cnt;
      rx_en = 1'b0;
      run_frame(16'h0555, 16'h0AAA, 16, -1, 1'b0);
      n_checks++;
      if (tick_cnt !== t0) begin n_fail++; $display("FAIL disarmed_ticks: got %0d, expected %0d", tick_cnt, t0); end
      n_checks++;
      if (dout !== 24'h001FFF) begin n_fail++; $display("FAIL disarmed_dout: got %h, expected 001fff", dout); end
      run_frame(16'h0321, 16'h0654, 16, 3, 1'b1);
      n_checks++;
      if (tick_cnt !== t0 + 1) begin n_fail++; $display("FAIL en_drop_ticks: got %0d, expected %0d", tick_cnt, t0 + 1); end
   endtask

   task automatic test_reset_midframe();
      int t0;
      logic [15:0] w0 = 16'h0555;
      logic [15:0] w1 = 16'h0AAA;
      cs = 1'b0;
      repeat (12) @(negedge clk);
      for (int k = 0; k < 8; k++) bit_cycle({w1[15-k], w0[15-k]});
      rst = 1'b0;
      #1;
      n_checks++;
      if (dout !== 24'h0) begin n_fail++; $display("FAIL midframe_reset_dout: got %h, expected 000000", dout); end
      sclk = 1'b0; cs = 1'b1; sdata = '0;
      repeat (CS_FILT + 4) @(negedge clk);
      t0  = tick_cnt;
      rst = 1'b1;
      repeat (20) @(negedge clk);
      n_checks++;
      if (tick_cnt !== t0) begin n_fail++; $display("FAIL release_ticks: got %0d, expected %0d", tick_cnt, t0); end
      n_checks++;
      if (dout !== 24'h0) begin n_fail++; $display("FAIL release_dout: got %h, expected 000000", dout); end
      run_frame(16'h0555, 16'h0AAA, 16, -1, 1'b1);
      n_checks++;
      if (dout !== 24'hAAA555) begin n_fail++; $display("FAIL post_reset_dout: got %h, expected aaa555", dout); end
   endtask

   task automatic test_lead_bits();
      int t0 = tick_cnt;
      run_frame(16'h0ABC, 16'h8123, 16, -1, 1'b1);
      n_checks++;
      if (tick_cnt !== t0 + 1) begin n_fail++; $display("FAIL lead_ticks: got %0d, expected %0d", tick_cnt, t0 + 1); end
      n_checks++;
      if (dout[23:12] !== 12'h123) begin n_fail++; $display("FAIL lead_dout_hi: got %h, expected 123", dout[23:12]); end
   endtask

   task automatic test_back_to_back();
      int t0 = tick_cnt;
      run_frame(16'h0001, 16'h0800, 16, -1, 1'b1);
      run_frame(16'h0FFE, 16'h07FF, 16, -1, 1'b1);
      n_checks++;
      if (tick_cnt !== t0 + 2) begin n_fail++; $display("FAIL b2b_ticks: got %0d, expected %0d", tick_cnt, t0 + 2); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cs_glitch();
      test_abort();
      test_rx_en();
      test_reset_midframe();
      test_lead_bits();
      test_back_to_back();
      repeat (10) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_frames: got %0d outstanding, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
